// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM pass arbiter: FSM state encoding,
// statistics counter widths and a small grant-decode helper.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_START     = 3'd3,
    ST_RUN       = 3'd4
  } arb_state_t;

  localparam int PASS_CNT_W = 32;
  localparam int WAIT_CNT_W = 16;

  // Expand a grant index (up to 8 requesters) into a one-hot vector.
  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/sdram_pass_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick. Returns the first set request
// bit at or after ptr, wrapping modulo NREQ. ptr is always < NREQ.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan candidates from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum  = {1'b0, ptr} + (IDX_W+1)'(k);
      cand = (sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum - (IDX_W+1)'(NREQ))
                                        : IDX_W'(sum);
      idx  = req[cand] ? cand : idx;
    end
  end

endmodule

// File: rtl/sdram_pass_arbiter.sv
// sdram_pass_arbiter: shares one sdram_control pass engine between NREQ
// requesters. Waits for SDRAM init, grants whole passes round-robin, issues
// a single-cycle start and steers wdat/ready/rdat to the granted requester.
// Optional statistics (pass_count, wait_max) are built when the macro
// SDRAM_ARB_STATS_EN is defined.
module sdram_pass_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 16,
  parameter int IDX_W  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_rnw,
  input  logic [NREQ*DATA_W-1:0]   req_wdat,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          req_done,
  output logic [DATA_W-1:0]        rdat,
  output logic                     init_done,
  output logic                     busy,
  output logic                     dram_start,
  output logic                     dram_rnw,
  output logic [DATA_W-1:0]        dram_wdat,
  input  logic                     dram_done,
  input  logic                     dram_ready,
  input  logic [DATA_W-1:0]        dram_rdat
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [NREQ*PASS_CNT_W-1:0] pass_count,
  output logic [WAIT_CNT_W-1:0]      wait_max
`endif
);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [NREQ-1:0]  gnt_next;
  logic [NREQ-1:0]  done_next;
  logic             busy_next;
  logic             rnw_next;
  logic             start_next;
  logic             init_next;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Route the engine handshake to/from the granted requester only.
  always_comb begin
    req_ready = {NREQ{dram_ready}} & gnt;
    rdat      = dram_rdat;
    dram_wdat = '0;
    for (int i = 0; i < NREQ; i++) begin
      dram_wdat = (idx == IDX_W'(i)) ? req_wdat[i*DATA_W +: DATA_W] : dram_wdat;
    end
  end

  // Next-state and next-output logic of the pass FSM.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    ptr_next   = ptr;
    gnt_next   = gnt;
    busy_next  = busy;
    rnw_next   = dram_rnw;
    init_next  = init_done;
    start_next = 1'b0;
    done_next  = '0;
    case (state)
      ST_WAIT_INIT: begin
        if (dram_done) begin
          init_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT_INIT;
        end
      end
      ST_IDLE: begin
        if (pick_valid) begin
          idx_next   = pick_idx;
          gnt_next   = NREQ'(idx_to_onehot(3'(pick_idx)));
          rnw_next   = req_rnw[pick_idx];
          busy_next  = 1'b1;
          state_next = ST_SETUP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // dram_rnw has been stable for a cycle; launch the pass.
        start_next = 1'b1;
        state_next = ST_START;
      end
      ST_START: begin
        start_next = 1'b0;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (dram_done) begin
          done_next  = NREQ'(idx_to_onehot(3'(idx)));
          gnt_next   = '0;
          busy_next  = 1'b0;
          ptr_next   = (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_WAIT_INIT;
        gnt_next   = '0;
        busy_next  = 1'b0;
        init_next  = 1'b0;
        rnw_next   = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT_INIT;
      idx        <= '0;
      ptr        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      dram_rnw   <= 1'b1;
      dram_start <= 1'b0;
      req_done   <= '0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      ptr        <= ptr_next;
      gnt        <= gnt_next;
      busy       <= busy_next;
      dram_rnw   <= rnw_next;
      dram_start <= start_next;
      req_done   <= done_next;
      init_done  <= init_next;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [PASS_CNT_W-1:0] pass_cnt [NREQ];
  logic [WAIT_CNT_W-1:0] wait_cnt [NREQ];
  logic [WAIT_CNT_W-1:0] wait_max_q;
  logic [WAIT_CNT_W-1:0] wait_peak;

  // Largest current wait run, folded with the recorded maximum.
  always_comb begin
    wait_peak = wait_max_q;
    for (int i = 0; i < NREQ; i++) begin
      wait_peak = (wait_cnt[i] > wait_peak) ? wait_cnt[i] : wait_peak;
    end
  end

  // Per-requester pass counters and wait-run counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        pass_cnt[i] <= '0;
        wait_cnt[i] <= '0;
      end
      wait_max_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_done[i]) begin
          pass_cnt[i] <= pass_cnt[i] + PASS_CNT_W'(1);
        end
        if (req[i] && !gnt[i]) begin
          if (wait_cnt[i] != {WAIT_CNT_W{1'b1}}) begin
            wait_cnt[i] <= wait_cnt[i] + WAIT_CNT_W'(1);
          end
        end else begin
          wait_cnt[i] <= '0;
        end
      end
      wait_max_q <= wait_peak;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    pass_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      pass_count[i*PASS_CNT_W +: PASS_CNT_W] = pass_cnt[i];
    end
    wait_max = wait_max_q;
  end
`endif

endmodule

// File: tb/tb_sdram_pass_arbiter.sv
// Scoreboard bench for sdram_pass_arbiter (NREQ=2, DATA_W=16). Stimulus
// pushes expected events; a monitor pops and compares them as the DUT
// presents grants, starts, ready strobes, done pulses and init completion.
module tb_sdram_pass_arbiter;

  localparam int K_INIT  = 0;
  localparam int K_GNT   = 1;
  localparam int K_START = 2;
  localparam int K_READY = 3;
  localparam int K_DONE  = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_rnw;
  logic [31:0] req_wdat;
  logic [1:0]  gnt;
  logic [1:0]  req_ready;
  logic [1:0]  req_done;
  logic [15:0] rdat;
  logic        init_done;
  logic        busy;
  logic        dram_start;
  logic        dram_rnw;
  logic [15:0] dram_wdat;
  logic        dram_done;
  logic        dram_ready;
  logic [15:0] dram_rdat;
`ifdef SDRAM_ARB_STATS_EN
  logic [63:0] pass_count;
  logic [15:0] wait_max;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;
    logic [47:0] val;
    int          gap;
  } ev_t;
  ev_t exp_q[$];

  sdram_pass_arbiter #(.NREQ(2), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_rnw    (req_rnw),
    .req_wdat   (req_wdat),
    .gnt        (gnt),
    .req_ready  (req_ready),
    .req_done   (req_done),
    .rdat       (rdat),
    .init_done  (init_done),
    .busy       (busy),
    .dram_start (dram_start),
    .dram_rnw   (dram_rnw),
    .dram_wdat  (dram_wdat),
    .dram_done  (dram_done),
    .dram_ready (dram_ready),
    .dram_rdat  (dram_rdat)
`ifdef SDRAM_ARB_STATS_EN
    ,
    .pass_count (pass_count),
    .wait_max   (wait_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_INIT:  return "init";
      K_GNT:   return "gnt";
      K_START: return "start";
      K_READY: return "ready";
      K_DONE:  return "done";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int kind, input logic [47:0] val, input int gap);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  task automatic check_ev(input int kind, input logic [47:0] act, input int since);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event, got val=%h", kname(kind), act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== act || (e.gap >= 0 && e.gap != since)) begin
        errors++;
        $display("FAIL %s: got kind=%s val=%h gap=%0d, required kind=%s val=%h gap=%0d",
                 kname(kind), kname(kind), act, since, kname(e.kind), e.val, e.gap);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic [1:0] prev_gnt;
    logic       prev_init;
    int         since;
    prev_gnt  = 2'b00;
    prev_init = 1'b0;
    since     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_gnt  = 2'b00;
        prev_init = 1'b0;
        since     = 0;
      end else begin
        since++;
        if (init_done && !prev_init) begin
          check_ev(K_INIT, 48'({init_done, gnt}), since);
          since = 0;
        end
        if (gnt != 2'b00 && gnt != prev_gnt) begin
          check_ev(K_GNT, 48'({busy, dram_rnw, gnt}), since);
          since = 0;
        end
        if (dram_start) begin
          check_ev(K_START, 48'({dram_rnw, gnt, busy}), since);
        end
        if (dram_ready) begin
          check_ev(K_READY, 48'({dram_rnw, req_ready, dram_wdat, rdat}), since);
        end
        if (req_done != 2'b00) begin
          check_ev(K_DONE, 48'({req_done, gnt, busy}), since);
          since = 0;
        end
        prev_gnt  = gnt;
        prev_init = init_done;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the start pulse, then step into the RUN state.
  task automatic wait_start();
    int n;
    n = 0;
    while (!dram_start && n < 40) begin
      cyc(1);
      n++;
    end
    if (!dram_start) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got dram_start=0 after %0d cycles, required 1", n);
    end else begin
      cyc(1);
    end
  endtask

  task automatic readies(input int n, input logic [1:0] g, input logic rnw, input logic [15:0] wd);
    for (int i = 0; i < n; i++) begin
      dram_rdat  = 16'h5A00 + 16'(i);
      dram_ready = 1'b1;
      push(K_READY, 48'({rnw, g, wd, dram_rdat}), -1);
      cyc(1);
      dram_ready = 1'b0;
      cyc(1);
    end
  endtask

  task automatic done_pulse(input logic [1:0] g);
    dram_done = 1'b1;
    push(K_DONE, 48'({g, 2'b00, 1'b0}), -1);
    cyc(1);
    dram_done = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    req        = 2'b00;
    req_rnw    = 2'b00;
    req_wdat   = {16'hA5A5, 16'h1234};
    dram_done  = 1'b0;
    dram_ready = 1'b0;
    dram_rdat  = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",   64'(gnt), 64'(0));
    chk("rst_done",  64'(req_done), 64'(0));
    chk("rst_start", 64'(dram_start), 64'(0));
    chk("rst_rnw",   64'(dram_rnw), 64'(1));
    chk("rst_init",  64'(init_done), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));

    // Init: req0 pending before init completes, granted only in IDLE.
    rst_n = 1'b1;
    req   = 2'b01;
    push(K_INIT,  48'({1'b1, 2'b00}), -1);
    push(K_GNT,   48'({1'b1, 1'b0, 2'b01}), 1);
    push(K_START, 48'({1'b0, 2'b01, 1'b1}), 1);
    cyc(8);
    chk("pre_init_gnt", 64'(gnt), 64'(0));
    cyc(1);
    dram_done = 1'b1;
    cyc(1);
    dram_done = 1'b0;

    // Pass A: requester 0 write; requester 1 joins.
    wait_start();
    req = 2'b11;
    readies(2, 2'b01, 1'b0, 16'h1234);
    done_pulse(2'b01);
    push(K_GNT,   48'({1'b1, 1'b0, 2'b10}), 1);
    push(K_START, 48'({1'b0, 2'b10, 1'b1}), 1);

    // Pass B: requester 1 write of A5A5; requester 0 switches to read.
    wait_start();
    req_rnw = 2'b01;
    readies(3, 2'b10, 1'b0, 16'hA5A5);
    done_pulse(2'b10);
    push(K_GNT,   48'({1'b1, 1'b1, 2'b01}), 1);
    push(K_START, 48'({1'b1, 2'b01, 1'b1}), 1);

    // Pass C: requester 0 read; drops req and flips rnw mid-pass.
    wait_start();
    req     = 2'b10;
    req_rnw = 2'b00;
    readies(2, 2'b01, 1'b1, 16'h1234);
    done_pulse(2'b01);
    push(K_GNT,   48'({1'b1, 1'b0, 2'b10}), 1);
    push(K_START, 48'({1'b0, 2'b10, 1'b1}), 1);

    // Pass D: requester 1 write; all requests drop, arbiter idles.
    wait_start();
    req = 2'b00;
    readies(1, 2'b10, 1'b0, 16'hA5A5);
    done_pulse(2'b10);
    cyc(4);

    // Pass E: reset asserted during RUN.
    req = 2'b01;
    push(K_GNT,   48'({1'b1, 1'b0, 2'b01}), -1);
    push(K_START, 48'({1'b0, 2'b01, 1'b1}), 1);
    wait_start();
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt",   64'(gnt), 64'(0));
    chk("midrst_start", 64'(dram_start), 64'(0));
    chk("midrst_init",  64'(init_done), 64'(0));
    chk("midrst_busy",  64'(busy), 64'(0));
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    push(K_INIT,  48'({1'b1, 2'b00}), -1);
    push(K_GNT,   48'({1'b1, 1'b0, 2'b01}), 1);
    push(K_START, 48'({1'b0, 2'b01, 1'b1}), 1);
    dram_done = 1'b1;
    cyc(1);
    dram_done = 1'b0;

    // Pass F: requester 0, held; back-to-back regrant after one IDLE cycle.
    wait_start();
    readies(1, 2'b01, 1'b0, 16'h1234);
    done_pulse(2'b01);
    push(K_GNT,   48'({1'b1, 1'b0, 2'b01}), 1);
    push(K_START, 48'({1'b0, 2'b01, 1'b1}), 1);

    // Pass G: requester 0 again; requester 1 joins.
    wait_start();
    req = 2'b11;
    readies(1, 2'b01, 1'b0, 16'h1234);
    done_pulse(2'b01);
    push(K_GNT,   48'({1'b1, 1'b0, 2'b10}), 1);
    push(K_START, 48'({1'b0, 2'b10, 1'b1}), 1);

    // Pass H: requester 1; then requester 0 only.
    wait_start();
    req = 2'b01;
    readies(1, 2'b10, 1'b0, 16'hA5A5);
    done_pulse(2'b10);
    push(K_GNT,   48'({1'b1, 1'b0, 2'b01}), 1);
    push(K_START, 48'({1'b0, 2'b01, 1'b1}), 1);

    // Pass I: requester 0, last pass.
    wait_start();
    req = 2'b00;
    readies(1, 2'b01, 1'b0, 16'h1234);
    done_pulse(2'b01);
    cyc(4);

`ifdef SDRAM_ARB_STATS_EN
    chk("pass_count0", 64'(pass_count[31:0]), 64'(3));
    chk("pass_count1", 64'(pass_count[63:32]), 64'(1));
`endif
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_pass_arbiter.md
Name: sdram_pass_arbiter

Overview:
- Shares one sdram_control pass engine (start/rnw/done/ready handshake, full-memory write or read pass) between NREQ requesters, e.g. mem_tester-style pattern checkers and a host/debug client.
- Waits for SDRAM init completion, then grants whole passes round-robin and issues the single-cycle start pulse.
- Steers wdat/ready/rdat between the engine and the granted requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 16, SDRAM data width; matches DRAM_DATA_SIZE.
- IDX_W, $clog2(NREQ) (min 1), width of the grant index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester pass request, level.
- req_rnw  in  NREQ  per-requester direction: 1 = read pass, 0 = write pass.
- req_wdat  in  NREQ*DATA_W  per-requester write data, slice i = requester i.
- gnt  out  NREQ  one-hot grant, held for the whole pass.
- req_ready  out  NREQ  dram_ready routed to the granted requester only.
- req_done  out  NREQ  one-cycle pass-complete pulse to the granted requester.
- rdat  out  DATA_W  dram_rdat passed through, valid where req_ready=1.
- init_done  out  1  SDRAM initialisation finished.
- busy  out  1  a pass is granted or in flight.
- dram_start  out  1  one-cycle start pulse to sdram_control.
- dram_rnw  out  1  direction to sdram_control.
- dram_wdat  out  DATA_W  req_wdat slice of the granted requester.
- dram_done  in  1  pass/init complete pulse from sdram_control.
- dram_ready  in  1  per-word strobe from sdram_control.
- dram_rdat  in  DATA_W  read data from sdram_control.

Behaviour:
- Reset values: gnt=0, req_done=0, dram_start=0, dram_rnw=1, init_done=0, busy=0, round-robin pointer=0, state=WAIT_INIT.
- Combinational outputs:
  - req_ready[i] = dram_ready & gnt[i].
  - dram_wdat = req_wdat slice selected by the grant index.
  - rdat = dram_rdat.
- States:
  - WAIT_INIT: no grants. On dram_done, set init_done=1 (sticky until reset) and go to IDLE.
  - IDLE: if any req bit is set, choose the first set bit at or after the pointer (wrapping modulo NREQ). Register the grant index, set gnt one-hot, dram_rnw=req_rnw[idx], busy=1. Go to SETUP.
  - SETUP: one cycle so dram_rnw is stable before start. Assert dram_start=1. Go to START.
  - START: dram_start=0. Go to RUN. dram_start is high for exactly one cycle per pass.
  - RUN: wait for dram_done. Then pulse req_done[idx]=1 for one cycle, clear gnt, busy=0, pointer=(idx+1) mod NREQ. Go to IDLE.
- Latency:
  - req seen in IDLE → gnt on the next edge.
  - dram_start high 2 cycles after req is sampled.
  - dram_done → req_done in the next cycle.
  - Next grant no earlier than the cycle after req_done.
- req/req_rnw are sampled only in IDLE:
  - Deasserting req or changing rnw mid-pass is ignored; the pass completes and req_done still fires.
  - A requester holding req after done is re-granted only after the other pending requesters (fairness).
- dram_done in IDLE/SETUP/START is ignored. dram_done coincident with the SETUP→START transition is not possible by contract with sdram_control.
- A single requester with req held continuously gets back-to-back passes: one IDLE cycle between req_done and the next gnt.
- Reset mid-pass: all state returns to reset values asynchronously. The engine shares rst_n and re-initialises, so the arbiter waits in WAIT_INIT again.

Optional Feature:
- SDRAM_ARB_STATS_EN defined:
  - Adds output pass_count[NREQ*32]: per-requester 32-bit counters incremented on each req_done, wrapping at 2^32-1→0, reset to 0.
  - Adds output wait_max[16]: longest count of cycles any requester waited with req high and no gnt, saturating at 16'hFFFF, reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sdram_arb_pkg:
  - state encoding (WAIT_INIT, IDLE, SETUP, START, RUN);
  - stats counter widths (32, 16).
- One sub-module: rr_pick (combinational round-robin priority pick). Inputs: req vector and pointer. Outputs: valid and index.

Test Plan:
- Reset, then dram_done pulse at cycle 10 → init_done=1 at cycle 11. req=2'b01 asserted before that gets no gnt until IDLE.
- After init, req=2'b11 with pointer=0 → gnt=2'b01, dram_rnw=req_rnw[0], one-cycle dram_start 2 cycles later. After dram_done: req_done=2'b01, then gnt=2'b10.
- Requester 1 write pass with req_wdat slice1=16'hA5A5 → dram_wdat=16'hA5A5 throughout RUN. dram_ready pulses appear only on req_ready[1].
- Requester 0 drops req mid-RUN → pass continues, req_done[0] pulses on dram_done, no re-grant to 0.
- Assert rst_n=0 during RUN → gnt=0, dram_start=0, init_done=0 immediately. No grant until the next dram_done.
- With SDRAM_ARB_STATS_EN: 3 passes for requester 0 and 1 for requester 1 → pass_count slice0=3, slice1=1.
